// File: rtl/ofm_pkg.sv
// Shared constants and FSM state type for the OFM write scheduler.
package ofm_pkg;
   localparam int DATA_WIDTH  = 512;
   localparam int BEAT_BYTES  = 64;
   localparam int LANES       = 4;
   localparam int BURST_LEN   = 64;
   localparam int CNT_W       = 11;
   localparam int FULL_THRESH = 1000;
   localparam int PAGE_BYTES  = 4096;
   localparam int REM_W       = 26;
   localparam int BURST_W     = 8;
   localparam int LANE_W      = $clog2(LANES);

   typedef enum logic [2:0] {IDLE, CALC, REQ, XFER, WAIT, NEXT, FIN} state_t;
endpackage

// File: rtl/ofm_wr_scheduler_if.sv
// Beat stream plus write-master request/completion between scheduler and AXI write master.
interface ofm_wr_scheduler_if;
   import ofm_pkg::*;

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  wmst_req;
   logic [63:0]           wmst_addr;
   logic [63:0]           wmst_xfer_size;
   logic                  wmst_done;

   modport master (
      output tdata, tvalid, wmst_req, wmst_addr, wmst_xfer_size,
      input  tready, wmst_done
   );

   modport slave (
      input  tdata, tvalid, wmst_req, wmst_addr, wmst_xfer_size,
      output tready, wmst_done
   );
endinterface

// File: rtl/ofm_burst_calc.sv
// Burst length = min(BURST_LEN, remaining beats, beats left in the current 4 KB page).
module ofm_burst_calc
   import ofm_pkg::*;
(
   input  logic [11:0]        page_off,
   input  logic [REM_W-1:0]   rem_beats,
   output logic [BURST_W-1:0] burst_beats
);
   logic [12:0]        page_rem_bytes;
   logic [6:0]         page_rem_beats;
   logic [BURST_W-1:0] min_a;

   always_comb begin
      page_rem_bytes = 13'(PAGE_BYTES) - {1'b0, page_off};
      page_rem_beats = page_rem_bytes[12:6];
      min_a = BURST_W'(BURST_LEN);
      if (rem_beats < REM_W'(min_a)) begin
         min_a = rem_beats[BURST_W-1:0];
      end
      burst_beats = min_a;
      if ({1'b0, page_rem_beats} < min_a) begin
         burst_beats = {1'b0, page_rem_beats};
      end
   end
endmodule

// File: rtl/ofm_wr_scheduler.sv
// Drains the per-lane OFM FIFOs round-robin onto one stream and schedules page-safe write bursts.
// states: IDLE wait start | CALC size burst | REQ issue request | XFER stream beats | WAIT await done | NEXT advance | FIN pulse done
module ofm_wr_scheduler
   import ofm_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        op_start,
   input  logic [63:0]                 ofm_base,
   input  logic [31:0]                 ofm_size,
   input  logic [LANES*DATA_WIDTH-1:0] lane_data,
   input  logic [LANES-1:0]            lane_empty,
   input  logic [LANES*CNT_W-1:0]      lane_cnt,
   output logic [LANES-1:0]            lane_pop,
   ofm_wr_scheduler_if.master          wr,
   output logic                        busy,
   output logic                        done,
   output logic                        stall
);
   state_t             state_q, state_d;
   logic [LANE_W-1:0]  ptr_q, ptr_d;
   logic [63:0]        addr_q, addr_d;
   logic [REM_W-1:0]   rem_beats_q, rem_beats_d;
   logic [BURST_W-1:0] burst_beats_q, burst_beats_d;
   logic [BURST_W-1:0] beats_left_q, beats_left_d;
   logic               done_seen_q, done_seen_d;
   logic               wmst_req_q, wmst_req_d;
   logic [63:0]        wmst_addr_q, wmst_addr_d;
   logic [63:0]        wmst_xfer_size_q, wmst_xfer_size_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BURST_W-1:0] calc_beats;
   logic               tvalid_c;
   logic               accept;

   ofm_burst_calc u_burst_calc (
      .page_off    (addr_q[11:0]),
      .rem_beats   (rem_beats_q),
      .burst_beats (calc_beats)
   );

   always_comb begin
      tvalid_c = (state_q == XFER) && !lane_empty[ptr_q] && (beats_left_q != '0);
      accept   = tvalid_c && wr.tready;
      lane_pop = accept ? (LANES'(1) << ptr_q) : '0;
      stall    = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_cnt[i*CNT_W +: CNT_W] >= CNT_W'(FULL_THRESH)) begin
            stall = 1'b1;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      addr_d           = addr_q;
      rem_beats_d      = rem_beats_q;
      burst_beats_d    = burst_beats_q;
      beats_left_d     = beats_left_q;
      done_seen_d      = done_seen_q;
      wmst_req_d       = 1'b0;
      wmst_addr_d      = wmst_addr_q;
      wmst_xfer_size_d = wmst_xfer_size_q;
      busy_d           = busy_q;
      done_d           = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_start) begin
               addr_d      = ofm_base & ~64'(BEAT_BYTES - 1);
               rem_beats_d = REM_W'(ofm_size >> 6);
               ptr_d       = '0;
               busy_d      = 1'b1;
               state_d     = CALC;
            end
         end
         CALC: begin
            if (rem_beats_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FIN;
            end else begin
               burst_beats_d    = calc_beats;
               beats_left_d     = calc_beats;
               wmst_req_d       = 1'b1;
               wmst_addr_d      = addr_q;
               wmst_xfer_size_d = 64'(calc_beats) << 6;
               state_d          = REQ;
            end
         end
         REQ: state_d = XFER;
         XFER: begin
            if (wr.wmst_done) begin
               done_seen_d = 1'b1;
            end
            if (accept) begin
               ptr_d        = (ptr_q == LANE_W'(LANES - 1)) ? '0 : ptr_q + LANE_W'(1);
               beats_left_d = beats_left_q - BURST_W'(1);
               // a completion seen before the final beat lets us skip WAIT
               if (beats_left_q == BURST_W'(1)) begin
                  state_d = (done_seen_q || wr.wmst_done) ? NEXT : WAIT;
               end
            end
         end
         WAIT: begin
            if (wr.wmst_done) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            addr_d      = addr_q + (64'(burst_beats_q) << 6);
            rem_beats_d = rem_beats_q - REM_W'(burst_beats_q);
            done_seen_d = 1'b0;
            state_d     = CALC;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         ptr_q            <= '0;
         addr_q           <= '0;
         rem_beats_q      <= '0;
         burst_beats_q    <= '0;
         beats_left_q     <= '0;
         done_seen_q      <= 1'b0;
         wmst_req_q       <= 1'b0;
         wmst_addr_q      <= '0;
         wmst_xfer_size_q <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         addr_q           <= addr_d;
         rem_beats_q      <= rem_beats_d;
         burst_beats_q    <= burst_beats_d;
         beats_left_q     <= beats_left_d;
         done_seen_q      <= done_seen_d;
         wmst_req_q       <= wmst_req_d;
         wmst_addr_q      <= wmst_addr_d;
         wmst_xfer_size_q <= wmst_xfer_size_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
      end
   end

   assign wr.tdata          = lane_data[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
   assign wr.tvalid         = tvalid_c;
   assign wr.wmst_req       = wmst_req_q;
   assign wr.wmst_addr      = wmst_addr_q;
   assign wr.wmst_xfer_size = wmst_xfer_size_q;
   assign busy              = busy_q;
   assign done              = done_q;
endmodule

// File: tb/tb_ofm_wr_scheduler.sv
// Bench for ofm_wr_scheduler: FIFO/write-master models and a burst-list reference built from the address rules.
module tb_ofm_wr_scheduler;
   import ofm_pkg::*;

   localparam int DW = 512;
   localparam int LN = 4;
   localparam int CW = 11;

   logic             clk = 1'b0;
   logic             rst;
   logic             op_start;
   logic [63:0]      ofm_base;
   logic [31:0]      ofm_size;
   logic [LN*DW-1:0] lane_data;
   logic [LN-1:0]    lane_empty;
   logic [LN*CW-1:0] lane_cnt;
   logic [LN-1:0]    lane_pop;
   logic             busy, done, stall;

   ofm_wr_scheduler_if wr_if ();

   ofm_wr_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .op_start   (op_start),
      .ofm_base   (ofm_base),
      .ofm_size   (ofm_size),
      .lane_data  (lane_data),
      .lane_empty (lane_empty),
      .lane_cnt   (lane_cnt),
      .lane_pop   (lane_pop),
      .wr         (wr_if),
      .busy       (busy),
      .done       (done),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   int            errs   = 0;
   int            checks = 0;
   logic [DW-1:0] fifo_q [LN][$];
   logic [LN-1:0] force_empty;
   int            cnt_model [LN];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] v;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic drive_lanes();
      for (int i = 0; i < LN; i++) begin
         lane_empty[i] = force_empty[i] || (fifo_q[i].size() == 0);
         lane_data[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
      end
   endtask

   task automatic set_cnt_check(input int c0, input int c1, input int c2, input int c3);
      bit exp;
      cnt_model[0] = c0; cnt_model[1] = c1; cnt_model[2] = c2; cnt_model[3] = c3;
      exp = 1'b0;
      for (int i = 0; i < LN; i++) begin
         lane_cnt[i*CW +: CW] = CW'(cnt_model[i]);
         if (cnt_model[i] >= 1000) exp = 1'b1;
      end
      #1;
      chk("stall", stall, exp);
   endtask

   // tmode: 0 tready always, 1 every other cycle, 2 random
   task automatic run_op(input logic [63:0] base, input logic [31:0] size, input int tmode,
                         input bit early, input bit gap2, input bit reissue, input int abort_beat);
      logic [63:0] q_addr [$];
      int          q_beats [$];
      logic [63:0] a;
      int          beats, n, pl, nb, bi, k, burst_left, wd_at, next_evt, lane, total;
      bit          exp_tv, acc, exp_req, exp_done, fin;
      a     = base & ~64'h3f;
      beats = int'(size >> 6);
      total = beats;
      while (beats > 0) begin
         pl = (4096 - int'(a[11:0])) / 64;
         n  = beats;
         if (n > 64) n = 64;
         if (n > pl) n = pl;
         q_addr.push_back(a);
         q_beats.push_back(n);
         a     = a + 64'(n * 64);
         beats = beats - n;
      end
      nb = q_addr.size();
      for (int i = 0; i < LN; i++) begin
         fifo_q[i].delete();
         for (int j = 0; j < total/LN + 2; j++) fifo_q[i].push_back(rand_beat());
      end
      force_empty = '0;
      bi = 0; k = 0; burst_left = 0; wd_at = -1; next_evt = 2; fin = 1'b0;
      for (int c = 0; !fin; c++) begin
         @(posedge clk); #1;
         op_start = (c == 0) || (reissue && c == 5);
         ofm_base = (c == 0) ? base : 64'h7777_0000;
         ofm_size = (c == 0) ? size : 32'h4000;
         case (tmode)
            0:       wr_if.tready = 1'b1;
            1:       wr_if.tready = (c % 2 == 1);
            default: wr_if.tready = ($urandom_range(0, 3) != 0);
         endcase
         wr_if.wmst_done = (c == wd_at);
         force_empty[2]  = gap2 && (c >= 4) && (c < 9);
         drive_lanes();
         #1;
         if (abort_beat >= 0 && k == abort_beat) return;
         exp_req  = (c == next_evt) && (bi < nb);
         exp_done = (c == next_evt) && (bi == nb);
         exp_tv   = (burst_left > 0) && !lane_empty[k % LN];
         acc      = exp_tv && wr_if.tready;
         chk("tvalid", wr_if.tvalid, exp_tv);
         chk("lane_pop", lane_pop, acc ? (1 << (k % LN)) : 0);
         chk("wmst_req", wr_if.wmst_req, exp_req);
         chk("done", done, exp_done);
         chk("busy", busy, (c >= 1) && !exp_done);
         if (acc) begin
            lane = k % LN;
            chk_w("tdata", wr_if.tdata, fifo_q[lane][0]);
            void'(fifo_q[lane].pop_front());
            k++;
            burst_left--;
            if (burst_left == 0) begin
               if (early) next_evt = c + 3;
               else begin
                  wd_at    = c + 1 + $urandom_range(0, 3);
                  next_evt = wd_at + 3;
               end
            end
         end
         if (exp_req) begin
            chk("wmst_addr", wr_if.wmst_addr, q_addr[bi]);
            chk("wmst_xfer_size", wr_if.wmst_xfer_size, 64'(q_beats[bi] * 64));
            burst_left = q_beats[bi];
            bi++;
            if (early) wd_at = c + 1;
         end
         if (exp_done) fin = 1'b1;
         assert (c < 3000) else begin
            errs++;
            $error("FAIL timeout cycle=%0d beats=%0d of %0d", c, k, total);
            fin = 1'b1;
         end
      end
      op_start = 1'b0;
      @(posedge clk); #2;
      chk("done_after", done, 1'b0);
      chk("busy_after", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; op_start = 1'b0; ofm_base = '0; ofm_size = '0;
      lane_data = '0; lane_empty = '1; lane_cnt = '0; force_empty = '0;
      wr_if.tready = 1'b0; wr_if.wmst_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", wr_if.tvalid, 1'b0);
      chk("rst_lane_pop", lane_pop, '0);
      chk("rst_wmst_req", wr_if.wmst_req, 1'b0);
      chk("rst_wmst_addr", wr_if.wmst_addr, '0);
      chk("rst_wmst_size", wr_if.wmst_xfer_size, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst = 1'b0;

      set_cnt_check(0, 0, 0, 0);
      set_cnt_check(0, 999, 0, 0);
      set_cnt_check(0, 0, 1000, 0);
      set_cnt_check(0, 0, 0, 2047);
      set_cnt_check(1500, 3, 998, 999);
      set_cnt_check(10, 20, 30, 40);

      run_op(64'h1000, 32'd128, 0, 1'b0, 1'b0, 1'b0, -1);
      run_op(64'h0FC0, 32'd256, 0, 1'b0, 1'b0, 1'b0, -1);
      run_op(64'h2000, 32'(80*64), 2, 1'b0, 1'b0, 1'b1, -1);
      run_op(64'h0, 32'(16*64), 1, 1'b0, 1'b1, 1'b0, -1);
      run_op(64'h0, 32'd0, 0, 1'b0, 1'b0, 1'b0, -1);
      run_op(64'h40, 32'(10*64), 2, 1'b1, 1'b0, 1'b0, -1);
      run_op(64'hFC0, 32'(5*64), 0, 1'b1, 1'b0, 1'b0, -1);

      run_op(64'h3_0000, 32'(64*64), 0, 1'b0, 1'b0, 1'b0, 10);
      rst = 1'b1;
      #1;
      chk("mid_rst_tvalid", wr_if.tvalid, 1'b0);
      chk("mid_rst_lane_pop", lane_pop, '0);
      chk("mid_rst_wmst_req", wr_if.wmst_req, 1'b0);
      chk("mid_rst_wmst_addr", wr_if.wmst_addr, '0);
      chk("mid_rst_wmst_size", wr_if.wmst_xfer_size, '0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      @(posedge clk); #1;
      chk("rst_hold_tvalid", wr_if.tvalid, 1'b0);
      rst = 1'b0;
      wr_if.wmst_done = 1'b0;
      run_op(64'h5000 | 64'h2d, 32'(9*64 + 13), 2, 1'b0, 1'b0, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         run_op({32'h0, $urandom}, 32'($urandom_range(0, 150*64 + 63)),
                2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
